pause_sequencer: RTL and testbench

Sequences the uP between run and paused operation. It merges the three pause request sources (synchronized pause pin, JTAG port, mapped-register CCTRL pause bit), drives the start-pause handshake to the core and waits for the core's acknowledge. It then asserts the formal paused state consumed by the memory controller, SPI controller, JTAG port and the state-indicator pin. It replaces the two-flop pause network at the top level and adds a drain timeout, a guaranteed resume window and cause reporting.

---
 rtl/pause_sequencer.sv | 157 +++++++++++++++
 tb/tb_pause_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pause_sequencer.sv
// pause_sequencer
//   Moves the uP between run and paused operation. The three pause sources
//   (synchronized pin, JTAG, CCTRL map bit) are merged into one request. The
//   block drives the start-pause handshake to the core and waits for the
//   core's acknowledge before it asserts the formal paused state. It also
//   bounds the drain with a timeout, holds a guaranteed resume window, and
//   reports which sources caused the pause.
//
// Ports
//   i_clk            system clock (only clock)
//   i_rstn           asynchronous active-low reset
//   i_isBooted       bootloader finished (level)
//   i_pinPause       synchronized pause pin request (level)
//   i_jtagPause      JTAG pause request (level)
//   i_mapPause       CCTRL pause bit (level)
//   i_coreNowPaused  core reports it is locally paused (level)
//   o_startPause     pause request to the core
//   o_isPaused       formal uP paused state
//   o_cause          sources behind the current pause, {map, jtag, pin}
//   o_timeout        sticky: the last pause attempt timed out
//
// State  | meaning
// BOOT   | bootloader running, requests ignored
// RUN    | normal operation, waiting for a pause request
// DRAIN  | start-pause asserted, waiting for the core ack (bounded by TIMEOUT)
// PAUSED | core acknowledged, formal paused state asserted
// RESUME | unpaused window of RESUME_CYCLES, requests ignored
module pause_sequencer #(
  parameter int TIMEOUT       = 16,
  parameter int RESUME_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_isBooted,
  input  logic       i_pinPause,
  input  logic       i_jtagPause,
  input  logic       i_mapPause,
  input  logic       i_coreNowPaused,
  output logic       o_startPause,
  output logic       o_isPaused,
  output logic [2:0] o_cause,
  output logic       o_timeout
);

  localparam int MAXCNT = (TIMEOUT > RESUME_CYCLES) ? TIMEOUT : RESUME_CYCLES;
  localparam int CW     = $clog2(MAXCNT + 1);

  localparam logic [CW-1:0] DRAIN_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] RESUME_LAST = CW'(RESUME_CYCLES - 1);

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    DRAIN,
    PAUSED,
    RESUME
  } stateT;

  stateT         state, stateNxt;
  logic [CW-1:0] cnt, cntNxt;
  logic [2:0]    causeNxt;
  logic          timeoutNxt;
  logic          startPauseNxt;
  logic          isPausedNxt;

  logic          req;
  logic [2:0]    src;

  assign req = i_pinPause | i_jtagPause | i_mapPause;
  assign src = {i_mapPause, i_jtagPause, i_pinPause};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= BOOT;
      cnt          <= '0;
      o_startPause <= 1'b0;
      o_isPaused   <= 1'b0;
      o_cause      <= 3'b000;
      o_timeout    <= 1'b0;
    end else begin
      state        <= stateNxt;
      cnt          <= cntNxt;
      o_startPause <= startPauseNxt;
      o_isPaused   <= isPausedNxt;
      o_cause      <= causeNxt;
      o_timeout    <= timeoutNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    cntNxt     = cnt;
    causeNxt   = o_cause;
    timeoutNxt = o_timeout;

    if (state != BOOT && !i_isBooted) begin
      // Losing boot overrides everything; no pause is in progress in BOOT,
      // so the cause report is cleared as well.
      stateNxt = BOOT;
      causeNxt = 3'b000;
    end else begin
      unique case (state)
        BOOT: begin
          if (i_isBooted) stateNxt = RUN;
        end
        RUN: begin
          if (req) begin
            stateNxt = DRAIN;
            causeNxt = src;
          end
        end
        DRAIN: begin
          causeNxt = o_cause | src;
          // Request drop beats ack, ack beats timeout.
          if (!req) begin
            stateNxt = RESUME;
          end else if (i_coreNowPaused) begin
            stateNxt   = PAUSED;
            timeoutNxt = 1'b0;
          end else if (cnt == DRAIN_LAST) begin
            stateNxt   = RESUME;
            timeoutNxt = 1'b1;
          end else begin
            cntNxt = cnt + CW'(1);
          end
        end
        PAUSED: begin
          causeNxt = o_cause | src;
          if (!req) begin
            stateNxt = RESUME;
          end else if (!i_coreNowPaused) begin
            stateNxt = DRAIN;
          end
        end
        RESUME: begin
          if (cnt == RESUME_LAST) begin
            stateNxt = RUN;
            causeNxt = 3'b000;
          end else begin
            cntNxt = cnt + CW'(1);
          end
        end
        default: begin
          stateNxt = BOOT;
        end
      endcase
    end

    // The shared counter restarts on every state change, including the
    // PAUSED -> DRAIN re-handshake.
    if (stateNxt != state) cntNxt = '0;

    startPauseNxt = (stateNxt == DRAIN) || (stateNxt == PAUSED);
    isPausedNxt   = (stateNxt == PAUSED);
  end

endmodule

// File: tb/tb_pause_sequencer.sv
module tb_pause_sequencer;

  localparam int TIMEOUT       = 16;
  localparam int RESUME_CYCLES = 2;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_isBooted;
  logic       i_pinPause;
  logic       i_jtagPause;
  logic       i_mapPause;
  logic       i_coreNowPaused;
  logic       o_startPause;
  logic       o_isPaused;
  logic [2:0] o_cause;
  logic       o_timeout;

  int checkCnt = 0;
  int passCnt  = 0;

  typedef struct {
    string      tag;
    logic       sp;
    logic       ip;
    logic [2:0] cause;
    logic       to;
    logic       chkCause;
  } expT;

  expT sb[$];

  pause_sequencer #(
    .TIMEOUT      (TIMEOUT),
    .RESUME_CYCLES(RESUME_CYCLES)
  ) dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_isBooted     (i_isBooted),
    .i_pinPause     (i_pinPause),
    .i_jtagPause    (i_jtagPause),
    .i_mapPause     (i_mapPause),
    .i_coreNowPaused(i_coreNowPaused),
    .o_startPause   (o_startPause),
    .o_isPaused     (o_isPaused),
    .o_cause        (o_cause),
    .o_timeout      (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Drive one cycle of inputs on the falling edge and queue what the DUT
  // must show after the following rising edge.
  task automatic step(input string tag, input logic b, p, j, m, a,
                      input logic sp, ip, input logic [2:0] c, input logic to,
                      input logic chkC);
    expT e;
    @(negedge i_clk);
    i_isBooted      = b;
    i_pinPause      = p;
    i_jtagPause     = j;
    i_mapPause      = m;
    i_coreNowPaused = a;
    e.tag = tag; e.sp = sp; e.ip = ip; e.cause = c; e.to = to; e.chkCause = chkC;
    sb.push_back(e);
  endtask

  always @(posedge i_clk) begin
    #1;
    if (sb.size() > 0) begin
      expT e;
      e = sb.pop_front();
      checkVal({e.tag, ".startPause"}, 8'(o_startPause), 8'(e.sp));
      checkVal({e.tag, ".isPaused"}, 8'(o_isPaused), 8'(e.ip));
      if (e.chkCause) checkVal({e.tag, ".cause"}, 8'(o_cause), 8'(e.cause));
      checkVal({e.tag, ".timeout"}, 8'(o_timeout), 8'(e.to));
    end
  end

  always @(negedge i_clk) begin
    if (i_rstn && o_isPaused) checkVal("paused_implies_start", 8'(o_startPause), 8'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rstn = 1'b0;
    i_isBooted = 0; i_pinPause = 0; i_jtagPause = 0; i_mapPause = 0; i_coreNowPaused = 0;
    #2;
    checkVal("reset.outputs", {o_startPause, o_isPaused, o_cause, o_timeout}, 8'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // BOOT ignores requests, then RUN one edge after boot.
    step("boot_jtag1", 0,0,1,0,0, 0,0,3'b000,0,1);
    step("boot_jtag2", 0,0,1,0,0, 0,0,3'b000,0,1);
    step("boot_done",  1,0,0,0,0, 0,0,3'b000,0,1);
    step("run_idle",   1,0,0,0,0, 0,0,3'b000,0,1);

    // Pin pause, ack three edges later, then map joins.
    step("pin_req",    1,1,0,0,0, 1,0,3'b001,0,1);
    step("pin_drain1", 1,1,0,0,0, 1,0,3'b001,0,1);
    step("pin_drain2", 1,1,0,0,0, 1,0,3'b001,0,1);
    step("pin_ack",    1,1,0,0,1, 1,1,3'b001,0,1);
    step("map_add",    1,1,0,1,1, 1,1,3'b101,0,1);
    step("map_gone",   1,1,0,0,1, 1,1,3'b101,0,1);

    // Release, pin re-asserted during RESUME is ignored until RUN.
    step("release",    1,0,0,0,1, 0,0,3'b101,0,1);
    step("resume_pin", 1,1,0,0,0, 0,0,3'b101,0,1);
    step("resume_run", 1,1,0,0,0, 0,0,3'b000,0,1);
    step("run_drain",  1,1,0,0,0, 1,0,3'b001,0,1);
    step("drain_drop", 1,0,0,0,0, 0,0,3'b001,0,1);
    step("resume_a",   1,0,0,0,0, 0,0,3'b001,0,1);
    step("resume_b",   1,0,0,0,0, 0,0,3'b000,0,1);

    // JTAG with no ack: DRAIN lasts exactly TIMEOUT cycles.
    for (int i = 0; i < TIMEOUT; i++)
      step("to_drain",   1,0,1,0,0, 1,0,3'b010,0,1);
    step("to_expire",    1,0,1,0,0, 0,0,3'b010,1,1);
    step("to_resume",    1,0,1,0,0, 0,0,3'b010,1,1);
    step("to_run",       1,0,1,0,0, 0,0,3'b000,1,1);
    step("to_redrain",   1,0,1,0,0, 1,0,3'b010,1,1);
    // Drop and ack together: drop wins, timeout unchanged.
    step("drop_ack",     1,0,0,0,1, 0,0,3'b010,1,1);
    step("da_resume",    1,0,0,0,0, 0,0,3'b010,1,1);
    step("da_run",       1,0,0,0,0, 0,0,3'b000,1,1);
    step("ok_drain",     1,0,1,0,0, 1,0,3'b010,1,1);
    step("ok_paused",    1,0,1,0,1, 1,1,3'b010,0,1);

    // Core drops its ack while PAUSED: re-handshake.
    step("core_drop",    1,0,1,0,0, 1,0,3'b010,0,1);
    step("core_reack",   1,0,1,0,1, 1,1,3'b010,0,1);
    step("rel2",         1,0,0,0,0, 0,0,3'b010,0,1);
    step("rel2_a",       1,0,0,0,0, 0,0,3'b010,0,1);
    step("rel2_run",     1,0,0,0,0, 0,0,3'b000,0,1);

    // Ack on the timeout edge: ack wins.
    step("edge_drain",   1,0,0,1,0, 1,0,3'b100,0,1);
    for (int i = 0; i < TIMEOUT - 1; i++)
      step("edge_wait",  1,0,0,1,0, 1,0,3'b100,0,1);
    step("edge_ack",     1,0,0,1,1, 1,1,3'b100,0,1);
    step("edge_hold",    1,0,0,1,1, 1,1,3'b100,0,1);

    // Asynchronous reset between edges while PAUSED.
    @(posedge i_clk);
    #3;
    checkVal("pre_reset.isPaused", 8'(o_isPaused), 8'd1);
    i_rstn = 1'b0;
    #1;
    checkVal("async_reset.outputs", {o_startPause, o_isPaused, o_cause, o_timeout}, 8'd0);
    @(negedge i_clk);
    i_isBooted = 0; i_pinPause = 0; i_jtagPause = 0; i_mapPause = 0; i_coreNowPaused = 0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    step("post_boot",    1,0,0,0,0, 0,0,3'b000,0,1);
    step("post_drain",   1,1,0,0,0, 1,0,3'b001,0,1);
    // Loss of boot overrides a pending request.
    step("unboot",       0,1,0,0,1, 0,0,3'b000,0,0);
    step("unboot_hold",  0,1,0,0,1, 0,0,3'b000,0,0);
    step("reboot",       1,0,0,0,0, 0,0,3'b000,0,1);

    @(negedge i_clk);
    @(negedge i_clk);
    checkVal("scoreboard_empty", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
